// File: rtl/wide_add_pkg.sv
// Shared defaults, FSM state type and width helpers for the wide adder scheduler.
package wide_add_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_WORDS  = 4;
    localparam int unsigned DEF_N_REQ  = 2;
    localparam int unsigned DEF_OP_W   = DEF_DATA_W * DEF_WORDS;
    localparam int unsigned DEF_ID_W   = $clog2(DEF_N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word counter width; stays at least one bit for single-word operands.
    function automatic int unsigned cnt_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder_word_cin.sv
// One DATA_W-bit adder slice with carry-in and carry-out; purely combinational.
module adder_word_cin
    import wide_add_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum_c,
    output logic              cout_c
);

    assign {cout_c, sum_c} = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);

endmodule

// File: rtl/wide_add_sched.sv
// Round-robin arbiter and word sequencer sharing one adder slice for wide adds.
// Optional subtract support is enabled by defining WIDE_ADD_SUB_EN.
module wide_add_sched
    import wide_add_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned WORDS  = DEF_WORDS,
    parameter int unsigned N_REQ  = DEF_N_REQ
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ*DATA_W*WORDS-1:0]   req_a,
    input  logic [N_REQ*DATA_W*WORDS-1:0]   req_b,
`ifdef WIDE_ADD_SUB_EN
    input  logic [N_REQ-1:0]                req_sub,
`endif
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(N_REQ)-1:0]        rsp_id,
    output logic [DATA_W*WORDS-1:0]         rsp_sum,
    output logic                            rsp_cout,
    output logic                            busy
);

    localparam int unsigned OP_W  = DATA_W * WORDS;
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = cnt_width(WORDS);

    state_t             state;
    state_t             state_nxt;

    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [OP_W-1:0]    sum_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               sub_q;
    logic               valid_q;
    logic               busy_q;

    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    scan;
    logic               gnt_found;
    logic               accept;
    logic               last_word;

    logic [OP_W-1:0]    sel_a;
    logic [OP_W-1:0]    sel_b;
    logic               sel_sub;

    logic [DATA_W-1:0]  word_b;
    logic [DATA_W-1:0]  word_sum;
    logic               word_cout;

    // Round-robin: first valid requester strictly after the last grant, cyclic.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan      = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan = (scan == ID_W'(N_REQ - 1)) ? '0 : scan + ID_W'(1);
            if (!gnt_found && req_valid[scan]) begin
                gnt_found = 1'b1;
                gnt_id    = scan;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
`ifdef WIDE_ADD_SUB_EN
                sel_sub = req_sub[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_word = (cnt_q == CNT_W'(WORDS - 1));
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: invert each B word, initial carry seeded with 1.
    assign word_b = b_q[DATA_W-1:0] ^ {DATA_W{sub_q}};

    adder_word_cin #(
        .DATA_W (DATA_W)
    ) u_adder (
        .a      (a_q[DATA_W-1:0]),
        .b      (word_b),
        .cin    (carry_q),
        .sum_c  (word_sum),
        .cout_c (word_cout)
    );

    // Operands shift down one word per RUN cycle; sum words shift in from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= (state_nxt == DONE);
            busy_q  <= (state_nxt != IDLE);
            if (accept) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                id_q    <= gnt_id;
                ptr_q   <= gnt_id;
                cnt_q   <= '0;
                carry_q <= sel_sub;
                sub_q   <= sel_sub;
            end else if (state == RUN) begin
                a_q     <= a_q >> DATA_W;
                b_q     <= b_q >> DATA_W;
                sum_q   <= OP_W'({word_sum, sum_q} >> DATA_W);
                carry_q <= word_cout;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last_word) begin
                    cout_q <= word_cout;
                end
            end
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wide_add_sched.sv
// Directed and randomized checks of wide_add_sched against an arithmetic reference model.
module tb_wide_add_sched;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned OP_W   = 128;

    typedef struct {
        int           id;
        logic [127:0] a;
        logic [127:0] b;
        logic         sub;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [1:0]   req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [127:0] rsp_sum;
    logic         rsp_cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    int           ptr_m;
    int           last_acc;
    int           n_acc;
    int           pend;
    int           g;
    logic [1:0]   hs;
    logic [128:0] e;
    txn_t         t;
    txn_t         q[$];
    logic [127:0] opa [2];
    logic [127:0] opb [2];
    logic         opsub [2];

    always #5 clk = ~clk;

    wide_add_sched #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .N_REQ  (N_REQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef WIDE_ADD_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: wide sum modulo 2^128; for subtract, carry-out means no borrow.
    function automatic logic [128:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input logic sub);
        if (sub) return {(a >= b), 128'(a - b)};
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic int model_grant(input logic [1:0] v, input int ptr);
        for (int off = 1; off <= int'(N_REQ); off++) begin
            int idx;
            idx = (ptr + off) % int'(N_REQ);
            if (((v >> idx) & 2'b01) != 2'b00) return idx;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_ops(input int r, input logic [127:0] a, input logic [127:0] b,
                           input logic sub);
        if (r == 0) begin
            req_a[127:0] = a;
            req_b[127:0] = b;
            req_sub[0]   = sub;
        end else begin
            req_a[255:128] = a;
            req_b[255:128] = b;
            req_sub[1]     = sub;
        end
    endtask

    task automatic refresh(input int r);
        opa[r] = rand128();
        opb[r] = rand128();
`ifdef WIDE_ADD_SUB_EN
        opsub[r] = 1'($urandom_range(1, 0));
`else
        opsub[r] = 1'b0;
`endif
        set_ops(r, opa[r], opb[r], opsub[r]);
    endtask

    // One transaction from requester r, holding the response for 'hold' cycles.
    task automatic run_op(input int r, input logic [127:0] a, input logic [127:0] b,
                          input logic sub, input int hold, input string tag);
        logic [128:0] exp_r;
        int           lat;
        exp_r = model(a, b, sub);
        step();
        set_ops(r, a, b, sub);
        req_valid = 2'b01 << r;
        #1;
        check({tag, "_ready"}, 160'(req_ready), 160'(2'b01 << r));
        step();
        req_valid = 2'b00;
        #1;
        check({tag, "_busy"}, 160'(busy), 160'(1));
        check({tag, "_early_valid"}, 160'(rsp_valid), 160'(0));
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            #1;
            lat++;
        end
        check({tag, "_latency"}, 160'(lat), 160'(WORDS + 1));
        check({tag, "_sum"}, 160'(rsp_sum), 160'(exp_r[127:0]));
        check({tag, "_cout"}, 160'(rsp_cout), 160'(exp_r[128]));
        check({tag, "_id"}, 160'(rsp_id), 160'(r));
        req_valid = 2'b11;
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_valid"}, 160'(rsp_valid), 160'(1));
            check({tag, "_hold_sum"}, 160'(rsp_sum), 160'(exp_r[127:0]));
            check({tag, "_hold_ready"}, 160'(req_ready), 160'(0));
            step();
            #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        #1;
        check({tag, "_valid_before_hs"}, 160'(rsp_valid), 160'(1));
        step();
        rsp_ready = 1'b0;
        #1;
        check({tag, "_valid_after_hs"}, 160'(rsp_valid), 160'(0));
        check({tag, "_idle"}, 160'(busy), 160'(0));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 2'b00;
        rsp_ready = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_valid", 160'(rsp_valid), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_sum", 160'(rsp_sum), 160'(0));
        check("rst_cout", 160'(rsp_cout), 160'(0));
        check("rst_id", 160'(rsp_id), 160'(0));
        check("rst_ready", 160'(req_ready), 160'(0));

        run_op(0, 128'hFFFF_FFFF, 128'h1, 1'b0, 0, "t1");
        run_op(1, {128{1'b1}}, 128'h1, 1'b0, 0, "t2");

        // Both requesters always valid: grants must alternate every WORDS+2 cycles.
        step();
        ptr_m    = 1;
        last_acc = -1;
        n_acc    = 0;
        q.delete();
        refresh(0);
        refresh(1);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 40) req_valid = 2'b00;
            #1;
            hs   = req_valid & req_ready;
            pend = -1;
            if (hs != 2'b00) begin
                g = model_grant(req_valid, ptr_m);
                check("t3_grant", 160'(hs), 160'(2'b01 << g));
                if (last_acc >= 0) check("t3_interval", 160'(c - last_acc), 160'(WORDS + 2));
                last_acc = c;
                ptr_m    = g;
                n_acc++;
                t.id  = g;
                t.a   = opa[g];
                t.b   = opb[g];
                t.sub = opsub[g];
                q.push_back(t);
                pend = g;
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    check("t3_spurious_rsp", 160'(1), 160'(0));
                end else begin
                    t = q.pop_front();
                    e = model(t.a, t.b, t.sub);
                    check("t3_sum", 160'(rsp_sum), 160'(e[127:0]));
                    check("t3_cout", 160'(rsp_cout), 160'(e[128]));
                    check("t3_id", 160'(rsp_id), 160'(t.id));
                end
            end
            step();
            if (pend >= 0) refresh(pend);
            if (c >= 40 && q.size() == 0 && !busy) break;
        end
        rsp_ready = 1'b0;
        check("t3_drained", 160'(q.size()), 160'(0));
        check("t3_accepts", 160'(n_acc >= 6), 160'(1));

        run_op(0, rand128(), rand128(), 1'b0, 10, "t4");

        // Reset while the third word is being added.
        step();
        set_ops(0, {128{1'b1}}, 128'h1, 1'b0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_busy", 160'(busy), 160'(0));
        check("t5_valid", 160'(rsp_valid), 160'(0));
        check("t5_sum", 160'(rsp_sum), 160'(0));
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_no_partial", 160'(rsp_valid), 160'(0));
        end
        req_valid = 2'b11;
        #1;
        check("t5_ptr_reset", 160'(req_ready), 160'(2'b01));
        req_valid = 2'b00;
        run_op(1, 128'h0, 128'h0, 1'b0, 0, "t5_zero");

        for (int i = 0; i < 6; i++) begin
            logic s;
`ifdef WIDE_ADD_SUB_EN
            s = 1'($urandom_range(1, 0));
`else
            s = 1'b0;
`endif
            run_op(int'($urandom_range(1, 0)), rand128(), rand128(), s, 0, "rnd");
        end

`ifdef WIDE_ADD_SUB_EN
        run_op(0, 128'd5, 128'd7, 1'b1, 0, "t6_neg");
        run_op(1, 128'd7, 128'd5, 1'b1, 0, "t6_pos");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
